// File: rtl/mem_pkg.sv
// Shared constants and the owner encoding for the unified memory port arbiter.
package mem_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (read-only) and
// load/store, granting one access per cycle with a registered one-cycle response.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = mem_pkg::ADDR_W,
  parameter int DATA_W   = mem_pkg::DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

  owner_t            owner;
  owner_t            owner_next;
  logic [WAIT_W-1:0] wait_cnt;

  // Data wins contention (older instruction) unless fetch has waited MAX_WAIT cycles.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (reset) begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end else if (if_req && (!d_req || (wait_cnt == MAX_WAIT_V))) begin
      if_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end else begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end
  end

  assign mem_addr    = d_gnt ? d_addr : if_addr;
  assign mem_data_in = d_wdata;
  assign mem_we      = d_gnt & d_we;

  // Next owner is whichever port was granted this cycle.
  always_comb begin
    owner_next = OWN_NONE;
    if (if_gnt) begin
      owner_next = OWN_FETCH;
    end else if (d_gnt) begin
      owner_next = OWN_DATA;
    end else begin
      owner_next = OWN_NONE;
    end
  end

  // Owner state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  // Response valid follows the owner, suppressed while reset is held.
  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (owner)
      OWN_FETCH: if_rvalid = !reset;
      OWN_DATA:  d_rvalid  = !reset;
      default: begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
      end
    endcase
  end

  // Capture read data into the granted port's register; stores leave d_rdata alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata <= {DATA_W{1'b0}};
      d_rdata  <= {DATA_W{1'b0}};
    end else begin
      if (if_gnt) begin
        if_rdata <= mem_data;
      end
      if (d_gnt && !d_we) begin
        d_rdata <= mem_data;
      end
    end
  end

  // Count consecutive denied fetch cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= {WAIT_W{1'b0}};
    end else if (!if_req || if_gnt) begin
      wait_cnt <= {WAIT_W{1'b0}};
    end else if (wait_cnt != MAX_WAIT_V) begin
      wait_cnt <= wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
